// File: rtl/bram_copy_engine_if.sv
// Command and BRAM-port bundle for bram_copy_engine.
// The engine takes the master modport: it is the BRAM's only master and the host's command target.
interface bram_copy_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH:0]   length;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic                  mem_we_a;
  logic [DATA_WIDTH-1:0] mem_din_a;
  logic [DATA_WIDTH-1:0] mem_dout_a;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic                  mem_we_b;
  logic [DATA_WIDTH-1:0] mem_din_b;

  modport master (
    input  start, mode, src_addr, dst_addr, length, fill_value, mem_dout_a,
    output busy, done, mem_addr_a, mem_we_a, mem_din_a, mem_addr_b, mem_we_b, mem_din_b
  );

  modport slave (
    output start, mode, src_addr, dst_addr, length, fill_value, mem_dout_a,
    input  busy, done, mem_addr_a, mem_we_a, mem_din_a, mem_addr_b, mem_we_b, mem_din_b
  );
endinterface

// File: rtl/bram_copy_engine.sv
// Block copy / block fill sequencer driving both ports of a read-first dual-port BRAM.
// Copy reads on port A and writes on port B one cycle behind; fill writes a constant on port B.
module bram_copy_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  bram_copy_engine_if.master  bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COPY  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] FILL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   cnt;       // words issued so far, including the one on the bus now
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  we_b_q;
  logic                  pass_dout;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [ADDR_WIDTH-1:0] cnt_lo;

  assign cnt_lo = cnt[ADDR_WIDTH-1:0];

  // NOTE: all state below updates with non-blocking assignments so every branch sees
  // pre-edge values; blocking here would make cnt/address updates order-dependent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      fill_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_b_q    <= 1'b0;
      pass_dout <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            len_q  <= bus.length;
            busy_q <= 1'b1;
            if (bus.length == '0) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else if (!bus.mode) begin
              addr_a_q <= bus.src_addr;
              cnt      <= CNT_ONE;
              state    <= COPY;
            end else begin
              fill_q   <= bus.fill_value;
              addr_b_q <= bus.dst_addr;
              we_b_q   <= 1'b1;
              cnt      <= CNT_ONE;
              state    <= FILL;
            end
          end
        end
        COPY: begin
          // The word read last cycle is on mem_dout_a now; write it next cycle.
          we_b_q    <= 1'b1;
          pass_dout <= 1'b1;
          addr_b_q  <= dst_q + (cnt_lo - ADDR_ONE);
          if (cnt == len_q) begin
            state <= DRAIN;
          end else begin
            addr_a_q <= src_q + cnt_lo;
            cnt      <= cnt + CNT_ONE;
          end
        end
        DRAIN: begin
          we_b_q    <= 1'b0;
          pass_dout <= 1'b0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        FILL: begin
          if (cnt == len_q) begin
            we_b_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            addr_b_q <= dst_q + cnt_lo;
            cnt      <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Copy data comes straight from the BRAM output register so each write lands
  // exactly one cycle behind its read; otherwise the captured fill word is driven.
  assign bus.mem_din_b  = pass_dout ? bus.mem_dout_a : fill_q;
  assign bus.mem_we_b   = we_b_q;
  assign bus.mem_addr_b = addr_b_q;
  assign bus.mem_addr_a = addr_a_q;
  assign bus.mem_we_a   = 1'b0;
  assign bus.mem_din_a  = '0;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: doc/bram_copy_engine.md
Name: bram_copy_engine

Overview:
- Sequencing controller that owns both ports of a synchronous dual-port BRAM (read-first, 1-cycle read latency, 2**ADDR_WIDTH words).
- Executes block copy (port A reads, port B writes) and block fill (port B writes a constant) on a single start command.
- Reports busy/done to the host logic.
- Sits between host/control logic and the BRAM instance. While busy, the engine is the BRAM's sole master.

Parameters:
- ADDR_WIDTH, 10, BRAM address width; memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, BRAM word width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; captured at start.
- src_addr  in  ADDR_WIDTH  copy source base; captured at start.
- dst_addr  in  ADDR_WIDTH  destination base; captured at start.
- length  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; captured at start.
- fill_value  in  DATA_WIDTH  fill word; captured at start.
- busy  out  1  high from the cycle after accept until the done cycle, inclusive.
- done  out  1  single-cycle completion pulse.
- mem_addr_a  out  ADDR_WIDTH  BRAM port A address.
- mem_we_a  out  1  BRAM port A write enable; always 0.
- mem_din_a  out  DATA_WIDTH  BRAM port A write data; always 0.
- mem_dout_a  in  DATA_WIDTH  BRAM port A read data; valid 1 cycle after address.
- mem_addr_b  out  ADDR_WIDTH  BRAM port B address.
- mem_we_b  out  1  BRAM port B write enable.
- mem_din_b  out  DATA_WIDTH  BRAM port B write data.

Behaviour:
- Reset: state IDLE, all outputs registered and reset to 0 (busy, done, mem_we_b, both addresses, mem_din_b). Any in-flight operation is abandoned immediately; no further writes are issued.
- FSM states: IDLE, COPY, DRAIN, FILL, DONE.
- IDLE:
  - start=1 and length=0: go to DONE; no BRAM access.
  - start=1 and length>0: capture command, reset word counter i=0, go to COPY (mode=0) or FILL (mode=1).
- COPY:
  - Each cycle, drive mem_addr_a = src+i and increment i.
  - Each port A read is followed one cycle later by a port B write: mem_we_b=1, mem_addr_b = dst+(i-1), mem_din_b = mem_dout_a.
  - After the read for i=length-1 is issued, go to DRAIN.
- DRAIN: perform the final write (dst+length-1), then go to DONE.
- Copy latency: length+1 cycles of BRAM activity, done in the following cycle.
- FILL:
  - Each cycle: mem_we_b=1, mem_addr_b = dst+i, mem_din_b = fill_value, increment i.
  - After i=length-1, go to DONE.
  - length cycles of writes; port A address holds its last value.
- DONE: done=1 for exactly one cycle, mem_we_b=0, then IDLE. busy drops in the cycle after DONE.
- Arithmetic:
  - All address sums are modulo 2**ADDR_WIDTH (wrap from max address to 0).
  - length=2**ADDR_WIDTH touches every word exactly once.
  - Counter width is ADDR_WIDTH+1.
- Overlap: no detection. Ordering is fixed: word k is read in cycle k and written in cycle k+1, both in ascending order.
  - With dst=src+1, each read returns the pre-copy value, because the BRAM is read-first and writes land one cycle behind reads.
  - Result for dst=src+1: a correct shift by one.
- start while busy is ignored; command inputs are ignored outside IDLE.
- mem_we_a and mem_din_a are tied 0.

Test Plan:
- Copy basic: preload addr 0..3 = 11,22,33,44; copy src=0, dst=100, len=4 -> addr 100..103 = 11,22,33,44. Exactly 5 mem_we_b cycles is wrong; check exactly 4. done pulses 6 cycles after the accept edge; busy width is 6 cycles.
- Fill with wrap: fill dst=1022, len=4, value=0xA5 (ADDR_WIDTH=10) -> addr 1022, 1023, 0, 1 = 0xA5. addr 2 and 1021 unchanged.
- Zero length: start, len=0 -> done one cycle later, mem_we_b never asserted, busy high for that 1 cycle only.
- Overlap shift: addr 10..13 = 1,2,3,4; copy src=10, dst=11, len=4 -> addr 11..14 = 1,2,3,4 and addr 10 = 1.
- Busy protection plus reset: start fill len=8; pulse start with a different command mid-run -> ignored. Assert reset on the 3rd write cycle -> exactly 3 words written, busy=0 and mem_we_b=0 on the next edge, no done pulse. A new command after reset completes normally.
